spi_cmd_ctrl: RTL and testbench
===============================

SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 SHALL have parameter MAGIC, default 8'hA5: byte presented on data_outgoing while idle.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 24'd12_000_000: maximum clk cycles spent in DATA (used only with the timeout feature).
REQ-003 SHALL have port clk  input  1  FPGA system clock; the only clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port ce0  input  1  raw SPI chip enable (asynchronous to clk, idle high).
REQ-006 SHALL have port data_incoming  input  8  byte received by the SPI slave; stable from the ce0 rise until the next ce0 fall.
REQ-007 SHALL have port status_in  input  8  hardware status; read-only at address 3.
REQ-008 SHALL have port data_outgoing  output  8  byte for the SPI slave to send in the next frame.
REQ-009 SHALL have port reg0, reg1, reg2  output  8 each  register file contents.
REQ-010 SHALL have port wr_strobe  output  3  one-hot one-cycle pulse marking which register was written.
REQ-011 SHALL have port busy  output  1  high while in state DATA.
REQ-012 SHALL have port timeout  output  1  one-cycle pulse when a transaction is aborted.

Function
REQ-013 SHALL pass ce0 through a 2-flop synchronizer plus 1 history flop; byte_done SHALL be high for one cycle when the synchronized value is 1 and the history value is 0.
REQ-014 SHALL implement FSM states IDLE and DATA.
REQ-015 SHALL, on byte_done in IDLE, decode cmd=data_incoming: bit7 = write(1)/read(0), bits[1:0] = addr, bits[6:2] ignored.
- Then: latch addr and write flag, and go to DATA.
REQ-016 SHALL, when that decode is a read, load data_outgoing on the next clk edge with reg[addr] for addr 0-2, or status_in for addr 3 (status_in sampled in the byte_done cycle).
REQ-017 SHALL, when that decode is a write, set data_outgoing to MAGIC.
REQ-018 SHALL, on byte_done in DATA with a latched write to addr 0-2, load reg[addr] with data_incoming and pulse wr_strobe[addr] on the next edge.
REQ-019 SHALL ignore a write to addr 3: no register change and no strobe.
REQ-020 SHALL, on byte_done in DATA, return to IDLE with data_outgoing=MAGIC, whether the command was a read or a write.
REQ-021 SHALL make data_outgoing valid 3 clk edges after the ce0 rise (2 sync + 1 update); the master ce0-high time SHALL be at least 4 clk periods.
REQ-022 SHALL drive busy = (state==DATA), registered.
REQ-023 SHALL ensure that a ce0 glitch shorter than 1 clk either produces no byte_done or produces exactly one.

Reset
REQ-024 SHALL, when rst is high at a clk edge, reset:
- state to IDLE;
- reg0-reg2 to 8'h00;
- data_outgoing to MAGIC;
- wr_strobe, busy and timeout to 0;
- sync and history flops to 1, so no byte_done occurs directly after reset;
- the timeout counter to 0.
REQ-025 SHALL, when rst is asserted mid-transaction, discard the pending transaction with no register write.

Configuration
REQ-026 SHALL, when SPI_CMD_TIMEOUT_EN is defined, clear a 24-bit counter on entry to DATA and increment it every cycle while in DATA.
- When the counter reaches TIMEOUT_CYCLES-1 without byte_done: go to IDLE, set data_outgoing=MAGIC, pulse timeout, and perform no write.
- If byte_done occurs in the same cycle, byte_done wins and timeout does not pulse.
REQ-027 SHALL, when SPI_CMD_TIMEOUT_EN is not defined, have no counter, tie timeout to 0, and hold DATA indefinitely.

Verification
REQ-028 SHALL cover: reset, then ce0 held high -> data_outgoing=8'hA5, regs=0, busy=0, no wr_strobe.
REQ-029 SHALL cover: frame 8'h81, then frame 8'h3C -> reg1=8'h3C, wr_strobe=3'b010 for one cycle, busy 1 then 0.
REQ-030 SHALL cover: after the write above, frame 8'h01 -> data_outgoing=8'h3C 3 clk after the ce0 rise; frame 8'h00 -> data_outgoing returns to 8'hA5.
REQ-031 SHALL cover: status_in=8'h5A, frame 8'h03 -> data_outgoing=8'h5A; frame 8'h83, then frame 8'hFF -> no wr_strobe, regs unchanged.
REQ-032 SHALL cover: frame 8'h82, then rst pulsed, then frame 8'h11 -> reg2 stays 8'h00 and the FSM treats 8'h11 as a read command of addr 1.
REQ-033 SHALL cover, with SPI_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100: frame 8'h80, then idle for 100 clk -> timeout pulses once, busy=0; a following frame 8'h77 is decoded as a command and reg0 is unchanged.

Source files
------------

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: decodes one-byte SPI commands into reads/writes of a 3-entry register file.
// Optional build macro SPI_CMD_TIMEOUT_EN aborts a DATA phase that stalls for TIMEOUT_CYCLES clocks.
module spi_cmd_ctrl #(
    parameter logic [7:0]  MAGIC          = 8'hA5,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce0,
    input  logic [7:0] data_incoming,
    input  logic [7:0] status_in,
    output logic [7:0] data_outgoing,
    output logic [7:0] reg0,
    output logic [7:0] reg1,
    output logic [7:0] reg2,
    output logic [2:0] wr_strobe,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {IDLE, DATA} state_t;

    state_t     state, state_n;
    logic       ce0_s1, ce0_s2, ce0_hist;
    logic       byte_done;
    logic [1:0] addr, addr_n;
    logic       wr, wr_n;
    logic [7:0] dout_n, reg0_n, reg1_n, reg2_n, rd_data;
    logic [2:0] strobe_n;

    // ce0 is asynchronous: two flops to resolve metastability, one more to find the rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            ce0_s1   <= 1'b1;
            ce0_s2   <= 1'b1;
            ce0_hist <= 1'b1;
        end else begin
            ce0_s1   <= ce0;
            ce0_s2   <= ce0_s1;
            ce0_hist <= ce0_s2;
        end
    end

    assign byte_done = ce0_s2 & ~ce0_hist;

    assign rd_data = data_incoming[1:0] == 2'd0 ? reg0 :
                     data_incoming[1:0] == 2'd1 ? reg1 :
                     data_incoming[1:0] == 2'd2 ? reg2 : status_in;

`ifdef SPI_CMD_TIMEOUT_EN
    logic [23:0] cnt, cnt_n;
    logic        timeout_n;

    // counter restarts at zero on every entry to DATA and runs only while DATA persists
    always_comb begin
        cnt_n = (state == DATA && state_n == DATA) ? cnt + 24'd1 : 24'd0;
    end

    // timeout pulse register and counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 24'd0;
            timeout <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            timeout <= timeout_n;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // next-state, register-file and outgoing-byte decisions
    always_comb begin
        state_n  = state;
        addr_n   = addr;
        wr_n     = wr;
        dout_n   = data_outgoing;
        reg0_n   = reg0;
        reg1_n   = reg1;
        reg2_n   = reg2;
        strobe_n = 3'b000;
`ifdef SPI_CMD_TIMEOUT_EN
        timeout_n = 1'b0;
`endif
        if (byte_done && state == IDLE) begin
            state_n = DATA;
            addr_n  = data_incoming[1:0];
            wr_n    = data_incoming[7];
            dout_n  = data_incoming[7] ? MAGIC : rd_data;
        end else if (byte_done) begin
            state_n = IDLE;
            dout_n  = MAGIC;
            if (wr && addr != 2'd3) begin
                reg0_n   = addr == 2'd0 ? data_incoming : reg0;
                reg1_n   = addr == 2'd1 ? data_incoming : reg1;
                reg2_n   = addr == 2'd2 ? data_incoming : reg2;
                strobe_n = 3'b001 << addr;
            end
        end
`ifdef SPI_CMD_TIMEOUT_EN
        else if (state == DATA && cnt == TIMEOUT_CYCLES - 24'd1) begin
            state_n   = IDLE;
            dout_n    = MAGIC;
            timeout_n = 1'b1;
        end
`endif
    end

    // state, register file and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr          <= 2'd0;
            wr            <= 1'b0;
            data_outgoing <= MAGIC;
            reg0          <= 8'h00;
            reg1          <= 8'h00;
            reg2          <= 8'h00;
            wr_strobe     <= 3'b000;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            addr          <= addr_n;
            wr            <= wr_n;
            data_outgoing <= dout_n;
            reg0          <= reg0_n;
            reg1          <= reg1_n;
            reg2          <= reg2_n;
            wr_strobe     <= strobe_n;
            busy          <= state_n == DATA;
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: directed frames with a queue-based scoreboard; define SPI_CMD_TIMEOUT_EN to also test the abort path.
module tb_spi_cmd_ctrl;

    typedef struct packed {
        logic       busy;
        logic [7:0] dout;
        logic [2:0] stb;
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] r2;
        logic       to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce0 = 1'b1;
    logic [7:0] data_incoming = 8'h00;
    logic [7:0] status_in = 8'h00;
    logic [7:0] data_outgoing, reg0, reg1, reg2;
    logic [2:0] wr_strobe;
    logic       busy, timeout;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t e;
    logic mon_en = 1'b0;
    logic prev_busy = 1'b0;

    spi_cmd_ctrl #(.MAGIC(8'hA5), .TIMEOUT_CYCLES(24'd100)) dut (
        .clk(clk), .rst(rst), .ce0(ce0), .data_incoming(data_incoming),
        .status_in(status_in), .data_outgoing(data_outgoing),
        .reg0(reg0), .reg1(reg1), .reg2(reg2), .wr_strobe(wr_strobe),
        .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic b, input logic [7:0] d, input logic [2:0] s,
                                input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                                input logic t);
        mk = '{busy: b, dout: d, stb: s, r0: a0, r1: a1, r2: a2, to: t};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%02h want=%02h @%0t", name, act, exp, $time);
        end
    endtask

    // monitor: every busy transition is one DUT response; pop and compare it
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy !== prev_busy) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event got busy=%0b want none @%0t", busy, $time);
                end else begin
                    e = q.pop_front();
                    chk("busy", {7'd0, busy}, {7'd0, e.busy});
                    chk("data_outgoing", data_outgoing, e.dout);
                    chk("wr_strobe", {5'd0, wr_strobe}, {5'd0, e.stb});
                    chk("reg0", reg0, e.r0);
                    chk("reg1", reg1, e.r1);
                    chk("reg2", reg2, e.r2);
                    chk("timeout", {7'd0, timeout}, {7'd0, e.to});
                end
            end else if (wr_strobe != 3'b000 || timeout) begin
                checks++;
                errors++;
                $display("FAIL stray_pulse got wr_strobe=%03b timeout=%0b want 0 @%0t", wr_strobe, timeout, $time);
            end
            prev_busy = busy;
        end
    end

    task automatic frame(input logic [7:0] b, input exp_t x, input logic tchk);
        @(negedge clk);
        ce0 = 1'b0;
        repeat (3) @(negedge clk);
        data_incoming = b;
        q.push_back(x);
        ce0 = 1'b1;
        if (tchk) begin
            repeat (2) @(posedge clk);
            #1 chk("dout_before_edge3", data_outgoing, 8'hA5);
            @(posedge clk);
            #1 chk("dout_at_edge3", data_outgoing, x.dout);
            repeat (4) @(negedge clk);
        end else begin
            repeat (6) @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_dout", data_outgoing, 8'hA5);
        chk("rst_reg0", reg0, 8'h00);
        chk("rst_reg1", reg1, 8'h00);
        chk("rst_reg2", reg2, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_strobe", {5'd0, wr_strobe}, 8'h00);
        chk("rst_timeout", {7'd0, timeout}, 8'h00);
        prev_busy = busy;
        mon_en = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_dout", data_outgoing, 8'hA5);
        chk("idle_busy", {7'd0, busy}, 8'h00);
        frame(8'h81, mk(1, 8'hA5, 3'b000, 8'h00, 8'h00, 8'h00, 0), 1'b0);
        frame(8'h3C, mk(0, 8'hA5, 3'b010, 8'h00, 8'h3C, 8'h00, 0), 1'b0);
        frame(8'h01, mk(1, 8'h3C, 3'b000, 8'h00, 8'h3C, 8'h00, 0), 1'b1);
        frame(8'h00, mk(0, 8'hA5, 3'b000, 8'h00, 8'h3C, 8'h00, 0), 1'b0);
        status_in = 8'h5A;
        frame(8'h03, mk(1, 8'h5A, 3'b000, 8'h00, 8'h3C, 8'h00, 0), 1'b0);
        frame(8'h00, mk(0, 8'hA5, 3'b000, 8'h00, 8'h3C, 8'h00, 0), 1'b0);
        frame(8'h83, mk(1, 8'hA5, 3'b000, 8'h00, 8'h3C, 8'h00, 0), 1'b0);
        frame(8'hFF, mk(0, 8'hA5, 3'b000, 8'h00, 8'h3C, 8'h00, 0), 1'b0);
        frame(8'h82, mk(1, 8'hA5, 3'b000, 8'h00, 8'h3C, 8'h00, 0), 1'b0);
        @(negedge clk);
        q.push_back(mk(0, 8'hA5, 3'b000, 8'h00, 8'h00, 8'h00, 0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        frame(8'h11, mk(1, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0), 1'b0);
        frame(8'h00, mk(0, 8'hA5, 3'b000, 8'h00, 8'h00, 8'h00, 0), 1'b0);
`ifdef SPI_CMD_TIMEOUT_EN
        frame(8'h80, mk(1, 8'hA5, 3'b000, 8'h00, 8'h00, 8'h00, 0), 1'b0);
        q.push_back(mk(0, 8'hA5, 3'b000, 8'h00, 8'h00, 8'h00, 1));
        repeat (110) @(negedge clk);
        frame(8'h77, mk(1, 8'h5A, 3'b000, 8'h00, 8'h00, 8'h00, 0), 1'b0);
        frame(8'h00, mk(0, 8'hA5, 3'b000, 8'h00, 8'h00, 8'h00, 0), 1'b0);
`endif
        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
